// File: rtl/rr_4_to_1_mux_arbiter.sv
// Round-robin 4:1 arbiter with optional burst lock feeding a shared mux into a one-entry output register.
// Latency: one cycle from input transfer to out_valid; full throughput while out_ready=1.
// Backpressure: when the output register is full and out_ready=0, in_ready is 0 and all state holds.
module rr_4_to_1_mux_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     in_valid,
    input  logic [4*N-1:0] in_data,
    output logic [3:0]     in_ready,
    output logic           out_valid,
    output logic [N-1:0]   out_data,
    output logic [1:0]     out_src,
    input  logic           out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     owner;
    logic [1:0]     owner_nxt;
    logic [1:0]     last;
    logic [CW-1:0]  burst_cnt;
    logic [CW-1:0]  burst_cnt_nxt;

    logic           load;
    logic           own_hold;
    logic           burst_last;
    logic           gnt_vld;
    logic [1:0]     gnt_idx;
    logic [1:0]     cand;
    logic           xfer;
    logic [N-1:0]   mux_dat;

    // The output register can take a new word when empty or being drained this cycle.
    assign load = !out_valid || out_ready;

    // The burst owner keeps the grant only while it is still presenting data.
    assign own_hold = (state == OWN) && in_valid[owner];

    // This transfer from the owner would complete its burst allowance.
    assign burst_last = (int'(burst_cnt) + 1 >= MAX_BURST);

    // Grant selection: locked owner first, else first valid requester after 'last'.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        if (rst_n && load) begin
            if (own_hold) begin
                gnt_vld = 1'b1;
                gnt_idx = owner;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    cand = last + 2'(k);
                    if (!gnt_vld && in_valid[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    // One-hot accept toward the granted requester.
    always_comb begin
        in_ready = 4'b0000;
        if (gnt_vld) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Shared 4:1 datapath mux; enable is "any grant", output forced to zero when idle.
    always_comb begin
        mux_dat = '0;
        if (gnt_vld) begin
            case (gnt_idx)
                2'd0:    mux_dat = in_data[0*N +: N];
                2'd1:    mux_dat = in_data[1*N +: N];
                2'd2:    mux_dat = in_data[2*N +: N];
                default: mux_dat = in_data[3*N +: N];
            endcase
        end
    end

    // Burst-lock next state; an absent owner is released and the RR winner may start a new burst.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        if (load) begin
            case (state)
                IDLE: begin
                    if (xfer && (MAX_BURST > 1)) begin
                        state_nxt     = OWN;
                        owner_nxt     = gnt_idx;
                        burst_cnt_nxt = CW'(1);
                    end
                end
                default: begin
                    if (own_hold) begin
                        if (burst_last) begin
                            state_nxt     = IDLE;
                            burst_cnt_nxt = '0;
                        end else begin
                            burst_cnt_nxt = burst_cnt + CW'(1);
                        end
                    end else if (xfer) begin
                        state_nxt     = OWN;
                        owner_nxt     = gnt_idx;
                        burst_cnt_nxt = CW'(1);
                    end else begin
                        state_nxt     = IDLE;
                        burst_cnt_nxt = '0;
                    end
                end
            endcase
        end
    end

    // Burst-lock state register; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 2'd0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Output stage and RR pointer: capture the winner, or empty when nothing transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            last      <= 2'd3;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_dat;
                out_src   <= gnt_idx;
                last      <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
